// File: rtl/rast_pkg.sv
// Shared definitions for the rectangle rasteriser: screen limits, field widths and FSM encoding.
package rast_pkg;

    localparam int unsigned HMaxDefault = 639;
    localparam int unsigned VMaxDefault = 479;
    localparam int unsigned XWidth      = 10;
    localparam int unsigned YWidth      = 9;
    localparam int unsigned ColorWidth  = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StEmit = 2'd2,
        StDone = 2'd3
    } rast_state_e;

endpackage

// File: rtl/rast_rect_norm.sv
// Combinational corner normalisation: order each axis low/high, then clamp to the screen limits.
module rast_rect_norm
    import rast_pkg::*;
#(
    parameter int unsigned H_MAX = HMaxDefault,
    parameter int unsigned V_MAX = VMaxDefault
) (
    input  logic [XWidth-1:0] x0_i,
    input  logic [XWidth-1:0] x1_i,
    input  logic [YWidth-1:0] y0_i,
    input  logic [YWidth-1:0] y1_i,
    output logic [XWidth-1:0] xmin_o,
    output logic [XWidth-1:0] xmax_o,
    output logic [YWidth-1:0] ymin_o,
    output logic [YWidth-1:0] ymax_o
);

    localparam logic [XWidth-1:0] HLimit = XWidth'(H_MAX);
    localparam logic [YWidth-1:0] VLimit = YWidth'(V_MAX);

    logic [XWidth-1:0] x_lo, x_hi;
    logic [YWidth-1:0] y_lo, y_hi;

    always_comb begin
        x_lo = (x0_i > x1_i) ? x1_i : x0_i;
        x_hi = (x0_i > x1_i) ? x0_i : x1_i;
        y_lo = (y0_i > y1_i) ? y1_i : y0_i;
        y_hi = (y0_i > y1_i) ? y0_i : y1_i;

        xmin_o = (x_lo > HLimit) ? HLimit : x_lo;
        xmax_o = (x_hi > HLimit) ? HLimit : x_hi;
        ymin_o = (y_lo > VLimit) ? VLimit : y_lo;
        ymax_o = (y_hi > VLimit) ? VLimit : y_hi;
    end

endmodule

// File: rtl/rast_rect_sender.sv
// Accepts a rectangle command and streams its pixels row by row to the frame buffer,
// one pixel per acknowledge, with abort on frame switch.
module rast_rect_sender
    import rast_pkg::*;
#(
    parameter int unsigned H_MAX = HMaxDefault,
    parameter int unsigned V_MAX = VMaxDefault
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [XWidth-1:0]     cmd_x0,
    input  logic [XWidth-1:0]     cmd_x1,
    input  logic [YWidth-1:0]     cmd_y0,
    input  logic [YWidth-1:0]     cmd_y1,
    input  logic [ColorWidth-1:0] cmd_color,
    input  logic                  next_frame_switch,
    output logic                  rast_pixel_rdy,
    output logic [ColorWidth-1:0] rast_color,
    output logic [XWidth-1:0]     rast_width,
    output logic [YWidth-1:0]     rast_height,
    output logic                  rast_done,
    input  logic                  read_rast_pixel_rdy
);

    rast_state_e state_q, state_d;

    logic [XWidth-1:0]     cx0_q, cx0_d, cx1_q, cx1_d;
    logic [YWidth-1:0]     cy0_q, cy0_d, cy1_q, cy1_d;
    logic [ColorWidth-1:0] color_q, color_d;
    logic [XWidth-1:0]     xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
    logic [YWidth-1:0]     ymax_q, ymax_d, y_q, y_d;

    logic [XWidth-1:0] norm_xmin, norm_xmax;
    logic [YWidth-1:0] norm_ymin, norm_ymax;
    logic              ack, last_pixel;

    rast_rect_norm #(
        .H_MAX (H_MAX),
        .V_MAX (V_MAX)
    ) u_norm (
        .x0_i   (cx0_q),
        .x1_i   (cx1_q),
        .y0_i   (cy0_q),
        .y1_i   (cy1_q),
        .xmin_o (norm_xmin),
        .xmax_o (norm_xmax),
        .ymin_o (norm_ymin),
        .ymax_o (norm_ymax)
    );

    assign ack        = (state_q == StEmit) && read_rast_pixel_rdy;
    assign last_pixel = (x_q == xmax_q) && (y_q == ymax_q);

    always_comb begin
        state_d = state_q;
        cx0_d   = cx0_q;
        cx1_d   = cx1_q;
        cy0_d   = cy0_q;
        cy1_d   = cy1_q;
        color_d = color_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        x_d     = x_q;
        y_d     = y_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cx0_d   = cmd_x0;
                    cx1_d   = cmd_x1;
                    cy0_d   = cmd_y0;
                    cy1_d   = cmd_y1;
                    color_d = cmd_color;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (next_frame_switch) begin
                    state_d = StIdle;
                end else begin
                    xmin_d  = norm_xmin;
                    xmax_d  = norm_xmax;
                    ymax_d  = norm_ymax;
                    x_d     = norm_xmin;
                    y_d     = norm_ymin;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                // Abort wins over a coincident acknowledge.
                if (next_frame_switch) begin
                    state_d = StIdle;
                end else if (ack) begin
                    if (last_pixel) begin
                        state_d = StDone;
                    end else if (x_q == xmax_q) begin
                        x_d = xmin_q;
                        y_d = y_q + YWidth'(1);
                    end else begin
                        x_d = x_q + XWidth'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cx0_q   <= '0;
            cx1_q   <= '0;
            cy0_q   <= '0;
            cy1_q   <= '0;
            color_q <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cx0_q   <= cx0_d;
            cx1_q   <= cx1_d;
            cy0_q   <= cy0_d;
            cy1_q   <= cy1_d;
            color_q <= color_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // cmd_ready is gated by rst so it reads 0 for the whole reset window.
    assign cmd_ready      = (state_q == StIdle) && !rst;
    assign rast_pixel_rdy = (state_q == StEmit);
    assign rast_done      = (state_q == StDone) && !next_frame_switch;
    assign rast_color     = color_q;
    assign rast_width     = x_q;
    assign rast_height    = y_q;

endmodule

// File: tb/tb_rast_rect_sender.sv
// Scoreboard bench for rast_rect_sender: directed scenarios plus random rectangles and ack patterns.
module tb_rast_rect_sender;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready;
    logic [9:0] cmd_x0, cmd_x1;
    logic [8:0] cmd_y0, cmd_y1;
    logic [2:0] cmd_color;
    logic       next_frame_switch;
    logic       rast_pixel_rdy, rast_done, read_rast_pixel_rdy;
    logic [2:0] rast_color;
    logic [9:0] rast_width;
    logic [8:0] rast_height;

    rast_rect_sender dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_x0              (cmd_x0),
        .cmd_x1              (cmd_x1),
        .cmd_y0              (cmd_y0),
        .cmd_y1              (cmd_y1),
        .cmd_color           (cmd_color),
        .next_frame_switch   (next_frame_switch),
        .rast_pixel_rdy      (rast_pixel_rdy),
        .rast_color          (rast_color),
        .rast_width          (rast_width),
        .rast_height         (rast_height),
        .rast_done           (rast_done),
        .read_rast_pixel_rdy (read_rast_pixel_rdy)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_pending = 0;

    logic       prev_rdy = 0, prev_ack = 0;
    logic [9:0] prev_w = 0;
    logic [8:0] prev_h = 0;
    logic [2:0] prev_c = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: the rectangle as a plain list of pixels in raster order.
    task automatic model_push(input int x0, input int x1, input int y0, input int y1,
                              input int c, output int xs, output int ys);
        int xl, xh, yl, yh;
        xl = (x0 < x1) ? x0 : x1;
        xh = (x0 < x1) ? x1 : x0;
        yl = (y0 < y1) ? y0 : y1;
        yh = (y0 < y1) ? y1 : y0;
        if (xl > 639) xl = 639;
        if (xh > 639) xh = 639;
        if (yl > 479) yl = 479;
        if (yh > 479) yh = 479;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                exp_q.push_back('{x: x, y: y, c: c});
        xs = xl;
        ys = yl;
    endtask

    // Monitor: pops the scoreboard on every acknowledged pixel, checks hold-stability and done.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_rdy && !prev_ack && rast_pixel_rdy) begin
                chk("hold_x", int'(rast_width), int'(prev_w));
                chk("hold_y", int'(rast_height), int'(prev_h));
                chk("hold_c", int'(rast_color), int'(prev_c));
            end
            if (rast_pixel_rdy && read_rast_pixel_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    pix_t p;
                    p = exp_q.pop_front();
                    chk("pix_x", int'(rast_width), p.x);
                    chk("pix_y", int'(rast_height), p.y);
                    chk("pix_c", int'(rast_color), p.c);
                end
            end
            if (rast_done) begin
                chk("done_expected", int'(done_pending > 0), 1);
                chk("done_all_pixels", exp_q.size(), 0);
                chk("done_rdy_low", int'(rast_pixel_rdy), 0);
                if (done_pending > 0) done_pending--;
            end
        end
        prev_rdy = rast_pixel_rdy;
        prev_ack = read_rast_pixel_rdy;
        prev_w   = rast_width;
        prev_h   = rast_height;
        prev_c   = rast_color;
    end

    // Returns at posedge+1 of the cycle in which the first pixel is presented.
    task automatic send_cmd(input int x0, input int x1, input int y0, input int y1, input int c);
        int n = 0;
        int xs, ys;
        @(posedge clk); #1;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_timeout", int'(cmd_ready), 1);
        cmd_valid = 1;
        cmd_x0    = 10'(x0);
        cmd_x1    = 10'(x1);
        cmd_y0    = 9'(y0);
        cmd_y1    = 9'(y1);
        cmd_color = 3'(c);
        model_push(x0, x1, y0, y1, c, xs, ys);
        done_pending++;
        @(posedge clk); #1;
        cmd_valid = 0;
        cmd_x0    = 10'($urandom);
        cmd_y0    = 9'($urandom);
        chk("load_rdy", int'(rast_pixel_rdy), 0);
        chk("load_cmd_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("first_rdy", int'(rast_pixel_rdy), 1);
        chk("first_x", int'(rast_width), xs);
        chk("first_y", int'(rast_height), ys);
    endtask

    // mode 0: ack held high, 1: random ack, 2: ack toggling
    task automatic wait_done(input int mode);
        int n = 0;
        while (done_pending != 0 && n < 4000) begin
            @(posedge clk); #1;
            case (mode)
                0:       read_rast_pixel_rdy = 1;
                1:       read_rast_pixel_rdy = 1'($urandom);
                default: read_rast_pixel_rdy = ~read_rast_pixel_rdy;
            endcase
            n++;
        end
        chk("done_timeout", done_pending, 0);
        read_rast_pixel_rdy = 0;
    endtask

    initial begin
        int x0, x1, y0, y1;
        rst = 1;
        cmd_valid = 0;
        cmd_x0 = 0; cmd_x1 = 0; cmd_y0 = 0; cmd_y1 = 0; cmd_color = 0;
        next_frame_switch = 0;
        read_rast_pixel_rdy = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_rdy", int'(rast_pixel_rdy), 0);
        chk("rst_done", int'(rast_done), 0);
        chk("rst_width", int'(rast_width), 0);
        chk("rst_height", int'(rast_height), 0);
        chk("rst_color", int'(rast_color), 0);
        rst = 0;
        #1;
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);

        // Back-to-back emission with exact done timing; frame switch in IDLE must be harmless.
        next_frame_switch = 1;
        read_rast_pixel_rdy = 1;
        @(posedge clk); #1;
        chk("nfs_idle_cmd_ready", int'(cmd_ready), 1);
        next_frame_switch = 0;
        send_cmd(2, 3, 3, 4, 5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("b2b_rdy", int'(rast_pixel_rdy), 1);
        end
        @(posedge clk); #1;
        chk("b2b_done", int'(rast_done), 1);
        chk("b2b_done_rdy", int'(rast_pixel_rdy), 0);
        @(posedge clk); #1;
        chk("b2b_done_single", int'(rast_done), 0);
        chk("b2b_idle_ready", int'(cmd_ready), 1);
        chk("b2b_pending", done_pending, 0);

        // Reversed corners beyond the screen limits.
        send_cmd(700, 638, 500, 478, 2);
        wait_done(0);

        // Degenerate rectangle with a delayed acknowledge.
        read_rast_pixel_rdy = 0;
        send_cmd(10, 10, 10, 10, 6);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("delay_rdy_held", int'(rast_pixel_rdy), 1);
        end
        read_rast_pixel_rdy = 1;
        @(posedge clk); #1;
        read_rast_pixel_rdy = 0;
        chk("delay_done", int'(rast_done), 1);
        @(posedge clk); #1;

        // Toggling acknowledge over a 3x1 rectangle.
        send_cmd(100, 102, 7, 7, 3);
        wait_done(2);

        // Abort coincident with the acknowledge of the second pixel.
        read_rast_pixel_rdy = 1;
        send_cmd(20, 23, 30, 33, 4);
        @(posedge clk); #1;
        next_frame_switch = 1;
        @(posedge clk); #1;
        next_frame_switch = 0;
        chk("abort_rdy", int'(rast_pixel_rdy), 0);
        chk("abort_done", int'(rast_done), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        chk("abort_left", exp_q.size(), 14);
        exp_q.delete();
        done_pending = 0;
        repeat (5) @(posedge clk);
        #1;
        read_rast_pixel_rdy = 0;

        // Asynchronous reset in the middle of emission.
        send_cmd(50, 53, 60, 63, 7);
        read_rast_pixel_rdy = 1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1;
        #1;
        chk("arst_rdy", int'(rast_pixel_rdy), 0);
        chk("arst_width", int'(rast_width), 0);
        chk("arst_height", int'(rast_height), 0);
        chk("arst_color", int'(rast_color), 0);
        chk("arst_cmd_ready", int'(cmd_ready), 0);
        exp_q.delete();
        done_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("arst_idle_ready", int'(cmd_ready), 1);
        read_rast_pixel_rdy = 0;
        send_cmd(5, 6, 8, 9, 1);
        wait_done(1);

        // Random rectangles with random acknowledge.
        for (int k = 0; k < 30; k++) begin
            x0 = $urandom_range(0, 1023);
            y0 = $urandom_range(0, 511);
            x1 = x0 + $urandom_range(0, 5);
            y1 = y0 + $urandom_range(0, 4);
            if (x1 > 1023) x1 = 1023;
            if (y1 > 511) y1 = 511;
            if ($urandom_range(0, 1) == 1) send_cmd(x1, x0, y0, y1, $urandom_range(0, 7));
            else send_cmd(x0, x1, y1, y0, $urandom_range(0, 7));
            wait_done(1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
